// File: rtl/tmr_sram_scrubber.sv
// Initiator for a triple-redundant SRAM. Host accesses always win the port,
// and idle cycles are used to vote each word and repair single-replica faults.
module tmr_sram_scrubber #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_WORDS      = 1024,
    parameter int SCRUB_INTERVAL = 1024,
    localparam int BE_WIDTH      = (DATA_WIDTH + 7) / 8,
    localparam int AW            = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [AW-1:0]         host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    input  logic [BE_WIDTH-1:0]   host_be_i,
    output logic                  host_gnt_o,
    output logic                  host_rvalid_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BE_WIDTH-1:0]   sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata0_i,
    input  logic [DATA_WIDTH-1:0] sram_rdata1_i,
    input  logic [DATA_WIDTH-1:0] sram_rdata2_i,
    output logic [31:0]           corrected_cnt_o,
    output logic                  uncorrectable_o,
    output logic [AW-1:0]         err_addr_o,
    output logic                  scrub_done_o
);

    localparam int CW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CW-1:0] INT_LAST  = CW'(SCRUB_INTERVAL - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

    state_t                  state_reg;
    logic [CW-1:0]           interval_reg;
    logic [AW-1:0]           scrub_addr_reg;
    logic [AW-1:0]           err_addr_reg;
    logic [DATA_WIDTH-1:0]   fix_data_reg;
    logic [31:0]             corrected_cnt_reg;
    logic                    uncorrectable_reg;
    logic                    scrub_done_reg;
    logic                    rvalid_reg;

    logic [DATA_WIDTH-1:0]   replica [3];
    logic [2:0]              pair_eq;
    logic [DATA_WIDTH-1:0]   voted;
    logic                    all_equal;
    logic                    all_differ;
    logic                    host_hit;
    logic                    scrub_rd;
    logic                    scrub_wr;
    logic                    advance;
    logic [AW-1:0]           scrub_addr_next;

    assign replica[0] = sram_rdata0_i;
    assign replica[1] = sram_rdata1_i;
    assign replica[2] = sram_rdata2_i;

    // pair_eq[0]: r0==r1, pair_eq[1]: r1==r2, pair_eq[2]: r2==r0
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pair
            assign pair_eq[gi] = (replica[gi] == replica[(gi + 1) % 3]);
        end
    endgenerate

    assign voted      = (pair_eq[0] || pair_eq[2]) ? replica[0] :
                        (pair_eq[1] ? replica[1] : replica[0]);
    assign all_equal  = pair_eq[0] && pair_eq[1];
    assign all_differ = ~|pair_eq;

    // A host write to the word under repair makes the pending writeback stale.
    assign host_hit = host_req_i && host_we_i && (host_addr_i == scrub_addr_reg);
    assign scrub_rd = (state_reg == READ) && enable_i && !host_req_i;
    assign scrub_wr = (state_reg == WRITE) && !host_req_i;
    assign advance  = ((state_reg == CHECK) && (all_equal || all_differ || host_hit)) ||
                      ((state_reg == WRITE) && (host_hit || !host_req_i));
    assign scrub_addr_next = (scrub_addr_reg == ADDR_LAST) ? '0 : scrub_addr_reg + AW'(1);

    assign host_gnt_o      = host_req_i;
    assign host_rvalid_o   = rvalid_reg;
    assign host_rdata_o    = voted;
    assign corrected_cnt_o = corrected_cnt_reg;
    assign uncorrectable_o = uncorrectable_reg;
    assign err_addr_o      = err_addr_reg;
    assign scrub_done_o    = scrub_done_reg;

    always_comb begin
        sram_req_o   = host_req_i;
        sram_we_o    = host_we_i;
        sram_addr_o  = host_addr_i;
        sram_wdata_o = host_wdata_i;
        sram_be_o    = host_be_i;
        if (scrub_rd) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b0;
            sram_addr_o = scrub_addr_reg;
            sram_be_o   = '1;
        end else if (scrub_wr) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = scrub_addr_reg;
            sram_wdata_o = fix_data_reg;
            sram_be_o    = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= IDLE;
            interval_reg      <= '0;
            scrub_addr_reg    <= '0;
            err_addr_reg      <= '0;
            fix_data_reg      <= '0;
            corrected_cnt_reg <= '0;
            uncorrectable_reg <= 1'b0;
            scrub_done_reg    <= 1'b0;
            rvalid_reg        <= 1'b0;
        end else begin
            rvalid_reg        <= host_req_i && !host_we_i;
            uncorrectable_reg <= 1'b0;
            scrub_done_reg    <= 1'b0;
            if (advance) begin
                scrub_addr_reg <= scrub_addr_next;
                scrub_done_reg <= (scrub_addr_reg == ADDR_LAST);
            end
            case (state_reg)
                IDLE: begin
                    if (!enable_i) begin
                        interval_reg <= '0;
                    end else if (interval_reg == INT_LAST) begin
                        interval_reg <= '0;
                        state_reg    <= READ;
                    end else begin
                        interval_reg <= interval_reg + CW'(1);
                    end
                end
                READ: begin
                    if (!enable_i) begin
                        state_reg <= IDLE;
                    end else if (!host_req_i) begin
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (!all_equal) begin
                        err_addr_reg <= scrub_addr_reg;
                    end
                    if (all_differ) begin
                        uncorrectable_reg <= 1'b1;
                    end
                    if (all_equal || all_differ || host_hit) begin
                        state_reg <= IDLE;
                    end else begin
                        fix_data_reg <= voted;
                        state_reg    <= WRITE;
                    end
                end
                WRITE: begin
                    if (host_hit) begin
                        state_reg <= IDLE;
                    end else if (!host_req_i) begin
                        state_reg <= IDLE;
                        if (corrected_cnt_reg != 32'hFFFF_FFFF) begin
                            corrected_cnt_reg <= corrected_cnt_reg + 32'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_sram_scrubber.sv
// Directed bench for tmr_sram_scrubber: 8-word, 64-bit memory with a scrub
// read every 6 cycles, behavioural triple-replica SRAM with injectable faults.
module tb_tmr_sram_scrubber;

    localparam int DW = 64;
    localparam int NW = 8;
    localparam int SI = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          enable;
    logic          host_req;
    logic          host_we;
    logic [2:0]    host_addr;
    logic [DW-1:0] host_wdata;
    logic [7:0]    host_be;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [2:0]    sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [7:0]    sram_be;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic [31:0]   corrected_cnt;
    logic          uncorrectable;
    logic [2:0]    err_addr;
    logic          scrub_done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    tmr_sram_scrubber #(
        .DATA_WIDTH    (DW),
        .NUM_WORDS     (NW),
        .SCRUB_INTERVAL(SI)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable),
        .host_req_i     (host_req),
        .host_we_i      (host_we),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .host_be_i      (host_be),
        .host_gnt_o     (host_gnt),
        .host_rvalid_o  (host_rvalid),
        .host_rdata_o   (host_rdata),
        .sram_req_o     (sram_req),
        .sram_we_o      (sram_we),
        .sram_addr_o    (sram_addr),
        .sram_wdata_o   (sram_wdata),
        .sram_be_o      (sram_be),
        .sram_rdata0_i  (rdata0),
        .sram_rdata1_i  (rdata1),
        .sram_rdata2_i  (rdata2),
        .corrected_cnt_o(corrected_cnt),
        .uncorrectable_o(uncorrectable),
        .err_addr_o     (err_addr),
        .scrub_done_o   (scrub_done)
    );

    // Replica model: shared base value, per-replica fault overlay, and words
    // written in the current epoch override both.
    logic [DW-1:0] base_val;
    logic [DW-1:0] ovr_val [3][NW];
    bit            ovr_en  [3][NW];
    logic [DW-1:0] wr_mem  [3][NW];
    int            wr_epoch[3][NW];
    int            epoch = 0;

    function automatic logic [DW-1:0] cur_word(input int r, input int a);
        if (wr_epoch[r][a] == epoch) return wr_mem[r][a];
        if (ovr_en[r][a]) return ovr_val[r][a];
        return base_val;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [7:0] be);
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < 8; b++) if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        return res;
    endfunction

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int r = 0; r < 3; r++) begin
                    wr_mem[r][sram_addr]   <= merge(cur_word(r, int'(sram_addr)), sram_wdata, sram_be);
                    wr_epoch[r][sram_addr] <= epoch;
                end
            end else begin
                rdata0 <= cur_word(0, int'(sram_addr));
                rdata1 <= cur_word(1, int'(sram_addr));
                rdata2 <= cur_word(2, int'(sram_addr));
            end
        end
    end

    // Monitor of scrub-originated port traffic and status pulses.
    int         cyc = 0;
    int         done_cnt = 0;
    int         unc_cnt = 0;
    logic [2:0] rd_addr_q[$];
    int         rd_cyc_q[$];
    logic [2:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [7:0] wr_be_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_ni && sram_req && !host_req) begin
            if (!sram_we) begin
                rd_addr_q.push_back(sram_addr);
                rd_cyc_q.push_back(cyc + 1);
                $display("[%0d] scrub read  addr=%0d", cyc + 1, sram_addr);
            end else begin
                wr_addr_q.push_back(sram_addr);
                wr_data_q.push_back(sram_wdata);
                wr_be_q.push_back(sram_be);
                $display("[%0d] scrub write addr=%0d data=%h be=%h", cyc + 1, sram_addr, sram_wdata, sram_be);
            end
        end
        if (rst_ni && scrub_done) done_cnt <= done_cnt + 1;
        if (rst_ni && uncorrectable) unc_cnt <= unc_cnt + 1;
    end

    int base_cyc, rd_base, wr_base, done_base, unc_base;

    task automatic do_reset(input logic [DW-1:0] base, input logic en);
        @(negedge clk);
        rst_ni = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = '0;
        enable = en;
        epoch++;
        base_val = base;
        for (int r = 0; r < 3; r++) for (int a = 0; a < NW; a++) ovr_en[r][a] = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        base_cyc = cyc; rd_base = rd_addr_q.size(); wr_base = wr_addr_q.size();
        done_base = done_cnt; unc_base = unc_cnt;
    endtask

    task automatic test_reset;
        epoch++;
        base_val = '0;
        @(negedge clk);
        rst_ni = 1'b0; enable = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd5; host_wdata = 64'hCAFE; host_be = 8'h0F;
        @(negedge clk);
        chk_cnt++;
        if ({host_gnt, sram_req, sram_we, sram_addr, sram_be} !== {1'b1, 1'b1, 1'b1, 3'd5, 8'h0F})
            $display("FAIL reset_mirror: got gnt/req/we/addr/be=%b/%b/%b/%0d/%h expected 1/1/1/5/0f",
                     host_gnt, sram_req, sram_we, sram_addr, sram_be);
        else pass_cnt++;
        chk_cnt++;
        if (sram_wdata !== 64'hCAFE) $display("FAIL reset_wdata: got %h expected cafe", sram_wdata);
        else pass_cnt++;
        chk_cnt++;
        if ({corrected_cnt, err_addr, uncorrectable, scrub_done} !== {32'd0, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset_stats: got cnt=%0d err=%0d unc=%b done=%b expected 0/0/0/0",
                     corrected_cnt, err_addr, uncorrectable, scrub_done);
        else pass_cnt++;
        host_we = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (host_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", host_rvalid);
        else pass_cnt++;
        host_req = 1'b0;
        #1;
        chk_cnt++;
        if ({host_gnt, sram_req} !== 2'b00) $display("FAIL reset_idle_port: got gnt/req=%b/%b expected 0/0", host_gnt, sram_req);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_periodic_scrub;
        int n;
        do_reset(64'h1234, 1'b1);
        repeat (52) @(negedge clk);
        enable = 1'b0;
        n = rd_addr_q.size() - rd_base;
        chk_cnt++;
        if (n !== 8) $display("FAIL periodic_read_count: got %0d expected 8", n);
        else pass_cnt++;
        for (int i = 0; i < n && i < 8; i++) begin
            logic [2:0] exp_a;
            int gap;
            exp_a = 3'(i);
            chk_cnt++;
            if (rd_addr_q[rd_base + i] !== exp_a)
                $display("FAIL periodic_addr[%0d]: got %0d expected %0d", i, rd_addr_q[rd_base + i], exp_a);
            else pass_cnt++;
            gap = (i == 0) ? rd_cyc_q[rd_base] - base_cyc : rd_cyc_q[rd_base + i] - rd_cyc_q[rd_base + i - 1];
            chk_cnt++;
            if (gap !== ((i == 0) ? 5 : 6))
                $display("FAIL periodic_spacing[%0d]: got %0d expected %0d", i, gap, (i == 0) ? 5 : 6);
            else pass_cnt++;
        end
        chk_cnt++;
        if (done_cnt - done_base !== 1) $display("FAIL periodic_done_pulses: got %0d expected 1", done_cnt - done_base);
        else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() - wr_base !== 0) $display("FAIL periodic_writes: got %0d expected 0", wr_addr_q.size() - wr_base);
        else pass_cnt++;
        chk_cnt++;
        if (corrected_cnt !== 32'd0) $display("FAIL periodic_corrected: got %0d expected 0", corrected_cnt);
        else pass_cnt++;
        $display("test_periodic_scrub done");
    endtask

    task automatic test_correction;
        do_reset(64'h1234, 1'b1);
        ovr_en[1][3] = 1'b1; ovr_val[1][3] = 64'hDEAD;
        repeat (24) @(negedge clk);
        chk_cnt++;
        if ({sram_req, sram_we, sram_addr, sram_be} !== {1'b1, 1'b1, 3'd3, 8'hFF})
            $display("FAIL correction_port: got req/we/addr/be=%b/%b/%0d/%h expected 1/1/3/ff", sram_req, sram_we, sram_addr, sram_be);
        else pass_cnt++;
        chk_cnt++;
        if (err_addr !== 3'd3) $display("FAIL correction_err_addr: got %0d expected 3", err_addr);
        else pass_cnt++;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        chk_cnt++;
        if (wr_addr_q.size() - wr_base !== 1) $display("FAIL correction_write_count: got %0d expected 1", wr_addr_q.size() - wr_base);
        else pass_cnt++;
        if (wr_addr_q.size() > wr_base) begin
            chk_cnt++;
            if ({wr_addr_q[wr_base], wr_data_q[wr_base], wr_be_q[wr_base]} !== {3'd3, 64'h1234, 8'hFF})
                $display("FAIL correction_write: got addr=%0d data=%h be=%h expected 3/1234/ff",
                         wr_addr_q[wr_base], wr_data_q[wr_base], wr_be_q[wr_base]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (corrected_cnt !== 32'd1) $display("FAIL correction_cnt: got %0d expected 1", corrected_cnt);
        else pass_cnt++;
        $display("test_correction done");
    endtask

    task automatic test_uncorrectable;
        do_reset(64'h0, 1'b1);
        ovr_en[0][5] = 1'b1; ovr_val[0][5] = 64'd1;
        ovr_en[1][5] = 1'b1; ovr_val[1][5] = 64'd2;
        ovr_en[2][5] = 1'b1; ovr_val[2][5] = 64'd3;
        repeat (36) @(negedge clk);
        chk_cnt++;
        if ({uncorrectable, err_addr} !== {1'b1, 3'd5})
            $display("FAIL uncorr_pulse: got unc=%b err=%0d expected 1/5", uncorrectable, err_addr);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (uncorrectable !== 1'b0) $display("FAIL uncorr_width: got %b expected 0", uncorrectable);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        chk_cnt++;
        if ({wr_addr_q.size() - wr_base, corrected_cnt, unc_cnt - unc_base} !== {32'd0, 32'd0, 32'd1})
            $display("FAIL uncorr_stats: got writes=%0d cnt=%0d pulses=%0d expected 0/0/1",
                     wr_addr_q.size() - wr_base, corrected_cnt, unc_cnt - unc_base);
        else pass_cnt++;
        chk_cnt++;
        if (rd_addr_q[rd_addr_q.size() - 1] !== 3'd6)
            $display("FAIL uncorr_advance: got %0d expected 6", rd_addr_q[rd_addr_q.size() - 1]);
        else pass_cnt++;
        $display("test_uncorrectable done");
    endtask

    task automatic test_host_stall;
        do_reset(64'h77, 1'b1);
        repeat (3) @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = 3'd6;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({host_gnt, sram_req, sram_we, sram_addr, host_rvalid, host_rdata} !== {1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 64'h77})
                $display("FAIL stall_host[%0d]: got gnt/req/we/addr/rvalid/rdata=%b/%b/%b/%0d/%b/%h expected 1/1/0/6/1/77",
                         i, host_gnt, sram_req, sram_we, sram_addr, host_rvalid, host_rdata);
            else pass_cnt++;
        end
        chk_cnt++;
        if (rd_addr_q.size() - rd_base !== 0) $display("FAIL stall_no_scrub: got %0d expected 0", rd_addr_q.size() - rd_base);
        else pass_cnt++;
        host_req = 1'b0;
        #1;
        chk_cnt++;
        if ({sram_req, sram_we, sram_addr} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL stall_release: got req/we/addr=%b/%b/%0d expected 1/0/0", sram_req, sram_we, sram_addr);
        else pass_cnt++;
        @(negedge clk);
        enable = 1'b0;
        chk_cnt++;
        if (rd_addr_q.size() - rd_base !== 1) $display("FAIL stall_one_read: got %0d expected 1", rd_addr_q.size() - rd_base);
        else pass_cnt++;
        $display("test_host_stall done");
    endtask

    task automatic test_cancel;
        do_reset(64'h55, 1'b1);
        ovr_en[2][2] = 1'b1; ovr_val[2][2] = 64'h99;
        repeat (18) @(negedge clk);
        chk_cnt++;
        if ({sram_req, sram_we, sram_addr, sram_wdata, err_addr} !== {1'b1, 1'b1, 3'd2, 64'h55, 3'd2})
            $display("FAIL cancel_pending: got req/we/addr/wdata/err=%b/%b/%0d/%h/%0d expected 1/1/2/55/2",
                     sram_req, sram_we, sram_addr, sram_wdata, err_addr);
        else pass_cnt++;
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd2; host_wdata = 64'hABCD; host_be = 8'h01;
        #1;
        chk_cnt++;
        if (sram_wdata !== 64'hABCD) $display("FAIL cancel_host_wins: got %h expected abcd", sram_wdata);
        else pass_cnt++;
        @(negedge clk);
        host_req = 1'b0; host_we = 1'b0;
        chk_cnt++;
        if ({wr_addr_q.size() - wr_base, corrected_cnt} !== {32'd0, 32'd0})
            $display("FAIL cancel_no_writeback: got writes=%0d cnt=%0d expected 0/0", wr_addr_q.size() - wr_base, corrected_cnt);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        chk_cnt++;
        if (rd_addr_q.size() - rd_base !== 4) $display("FAIL cancel_read_count: got %0d expected 4", rd_addr_q.size() - rd_base);
        else pass_cnt++;
        chk_cnt++;
        if ({rd_addr_q[rd_addr_q.size() - 1], 32'(rd_cyc_q[rd_cyc_q.size() - 1] - base_cyc)} !== {3'd3, 32'd24})
            $display("FAIL cancel_next_addr: got addr=%0d cyc=%0d expected 3/24",
                     rd_addr_q[rd_addr_q.size() - 1], rd_cyc_q[rd_cyc_q.size() - 1] - base_cyc);
        else pass_cnt++;
        $display("test_cancel done");
    endtask

    task automatic test_host_read;
        logic [2:0]    va [3] = '{3'd4, 3'd1, 3'd6};
        logic [DW-1:0] v0 [3] = '{64'd7, 64'd5, 64'd1};
        logic [DW-1:0] v1 [3] = '{64'd9, 64'd8, 64'd2};
        logic [DW-1:0] v2 [3] = '{64'd7, 64'd8, 64'd3};
        logic [DW-1:0] ve [3] = '{64'd7, 64'd8, 64'd1};
        do_reset(64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ovr_en[0][va[i]] = 1'b1; ovr_val[0][va[i]] = v0[i];
            ovr_en[1][va[i]] = 1'b1; ovr_val[1][va[i]] = v1[i];
            ovr_en[2][va[i]] = 1'b1; ovr_val[2][va[i]] = v2[i];
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_req = 1'b1; host_we = 1'b0; host_addr = va[i];
            #1;
            chk_cnt++;
            if (host_gnt !== 1'b1) $display("FAIL hostrd_gnt[%0d]: got %b expected 1", i, host_gnt);
            else pass_cnt++;
            @(negedge clk);
            host_req = 1'b0;
            chk_cnt++;
            if ({host_rvalid, host_rdata} !== {1'b1, ve[i]})
                $display("FAIL hostrd_data[%0d]: got rvalid=%b rdata=%h expected 1/%h", i, host_rvalid, host_rdata, ve[i]);
            else pass_cnt++;
            @(negedge clk);
            chk_cnt++;
            if (host_rvalid !== 1'b0) $display("FAIL hostrd_rvalid_drop[%0d]: got %b expected 0", i, host_rvalid);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({corrected_cnt, err_addr, 32'(unc_cnt - unc_base)} !== {32'd0, 3'd0, 32'd0})
            $display("FAIL hostrd_stats: got cnt=%0d err=%0d unc=%0d expected 0/0/0", corrected_cnt, err_addr, unc_cnt - unc_base);
        else pass_cnt++;
        $display("test_host_read done");
    endtask

    task automatic test_reset_in_write;
        do_reset(64'hAAAA, 1'b1);
        ovr_en[1][0] = 1'b1; ovr_val[1][0] = 64'hBAD;
        ovr_en[1][1] = 1'b1; ovr_val[1][1] = 64'hBAD;
        repeat (13) @(negedge clk);
        chk_cnt++;
        if ({corrected_cnt, err_addr, sram_we, sram_addr} !== {32'd1, 3'd1, 1'b1, 3'd1})
            $display("FAIL rstwr_pending: got cnt=%0d err=%0d we=%b addr=%0d expected 1/1/1/1",
                     corrected_cnt, err_addr, sram_we, sram_addr);
        else pass_cnt++;
        rst_ni = 1'b0;
        #1;
        chk_cnt++;
        if ({corrected_cnt, err_addr, sram_req} !== {32'd0, 3'd0, 1'b0})
            $display("FAIL rstwr_async: got cnt=%0d err=%0d req=%b expected 0/0/0", corrected_cnt, err_addr, sram_req);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wr_addr_q.size() - wr_base !== 1) $display("FAIL rstwr_discarded: got %0d expected 1", wr_addr_q.size() - wr_base);
        else pass_cnt++;
        enable = 1'b0;
        rst_ni = 1'b1;
        $display("test_reset_in_write done");
    endtask

    initial begin
        rst_ni = 1'b0; enable = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = '0;
        test_reset();
        test_periodic_scrub();
        test_correction();
        test_uncorrectable();
        test_host_stall();
        test_cancel();
        test_host_read();
        test_reset_in_write();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tmr_sram_scrubber.md
Name: tmr_sram_scrubber

Overview:
- Initiator-side companion to the triple-redundant SRAM: drives the single req/we/addr/wdata/be port shared by three replica banks and receives all three replica read words.
- Services host accesses with strict priority and returns majority-voted read data to the host.
- In idle port cycles it walks every word, votes the three copies and writes the majority back on a single-replica fault.
- Reports correction and uncorrectable-fault statistics.

Parameters:
- DATA_WIDTH, 64, word width in bits. BE width is (DATA_WIDTH+7)/8.
- NUM_WORDS, 1024, memory depth. AW = $clog2(NUM_WORDS).
- SCRUB_INTERVAL, 1024, idle cycles between scrub reads. Must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  scrub enable
- host_req_i / host_we_i  in  1 / 1  host request / write
- host_addr_i  in  AW  host address
- host_wdata_i  in  DATA_WIDTH  host write data
- host_be_i  in  BE  host byte enables
- host_gnt_o  out  1  host grant
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  DATA_WIDTH  voted read data
- sram_req_o / sram_we_o  out  1 / 1  memory request / write
- sram_addr_o  out  AW  memory address
- sram_wdata_o  out  DATA_WIDTH  memory write data
- sram_be_o  out  BE  memory byte enables
- sram_rdata0_i, sram_rdata1_i, sram_rdata2_i  in  DATA_WIDTH each  replica read words
- corrected_cnt_o  out  32  scrub writebacks performed
- uncorrectable_o  out  1  one-cycle pulse, all three copies differ
- err_addr_o  out  AW  address of last corrected or uncorrectable word
- scrub_done_o  out  1  one-cycle pulse on address wrap

Behaviour:
- Memory read latency: rdata inputs are valid the cycle after a read request.
- Vote: result = r0 if r0==r1 or r0==r2; else r1 if r1==r2; else r0, flagged uncorrectable.

Host path:
- host_gnt_o = host_req_i combinationally, always. The host owns the port whenever it requests, and during reset.
- host_rvalid_o is asserted one cycle after a granted host read.
- host_rdata_o is the vote of the current rdata inputs.
- Host reads never touch the statistics.

Scrub FSM states: IDLE, READ, CHECK, WRITE.
- IDLE: interval counter counts while enable_i=1. When it reaches SCRUB_INTERVAL-1, clear it and go to READ. enable_i=0 clears the counter.
- READ: when host_req_i=0, drive a read of scrub_addr and go to CHECK. Otherwise stall in READ. enable_i=0 returns to IDLE.
- CHECK: vote the rdata inputs.
  - All equal: advance scrub_addr, go to IDLE.
  - Exactly one replica differs: latch the majority word, set err_addr_o, go to WRITE.
  - All three differ: pulse uncorrectable_o, set err_addr_o, advance, go to IDLE.
- WRITE: when host_req_i=0, write the latched word to scrub_addr with be all ones. Increment corrected_cnt_o (saturating at 2^32-1), advance, go to IDLE.
- Writeback cancel: a granted host write to scrub_addr during CHECK or WRITE (any be) cancels the writeback. The FSM advances to IDLE and the counter is unchanged. The host data is newer.
- Address advance: scrub_addr wraps NUM_WORDS-1 → 0 and pulses scrub_done_o in that cycle.
- Reset values:
  - State IDLE; scrub_addr, counter and corrected_cnt_o = 0.
  - err_addr_o = 0; uncorrectable_o, scrub_done_o and host_rvalid_o = 0.
  - sram_* outputs mirror the host inputs when host_req_i=1, else sram_req_o=0.
- Reset mid-operation discards any pending writeback.

Test Plan:
- SCRUB_INTERVAL=4, NUM_WORDS=8, all replicas equal, enable_i=1 → one scrub read every 6 cycles. scrub_done_o pulses once after address 7. corrected_cnt_o stays 0.
- Replica 1 returns 0xDEAD at addr 3, others return 0x1234 → write of 0x1234 to addr 3 with be=0xFF. corrected_cnt_o=1, err_addr_o=3.
- Replicas return 1, 2, 3 at addr 5 → uncorrectable_o pulses one cycle, err_addr_o=5, no write, counter unchanged.
- Host requests continuously during READ for 20 cycles → host granted every cycle and the scrub stalls. The scrub read issues in the first cycle with host_req_i=0.
- Pending writeback to addr 2, host writes addr 2 → writeback cancelled, corrected_cnt_o unchanged, next scrub address 3.
- Host read with replicas 7, 9, 7 → host_rvalid_o next cycle with host_rdata_o=7. rst_ni low in WRITE → state IDLE and all counters 0 immediately.
